// File: rtl/dcache_pkg.sv
// Shared types and address-split constants for the direct-mapped data cache.
// The optional DCACHE_STATS_EN build adds hit/miss counters in dcache_ctrl.
package dcache_pkg;

    localparam int BYTE_OFF_BITS = 2;
    localparam int WORD_OFF_BITS = 2;
    localparam int LINE_WORDS    = 1 << WORD_OFF_BITS;
    localparam int INDEX_LSB     = BYTE_OFF_BITS + WORD_OFF_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_e;

    function automatic int tag_w(input int addr_w, input int index_bits);
        return addr_w - index_bits - INDEX_LSB;
    endfunction

    function automatic int num_lines(input int index_bits);
        return 1 << index_bits;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays for the cache: one combinational lookup port, one word
// write port, and per-line invalidate / fill-complete controls.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = 8,
    parameter int DATA_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INDEX_BITS-1:0]    rd_index,
    input  logic [WORD_OFF_BITS-1:0] rd_word,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_en,
    input  logic [INDEX_BITS-1:0]    wr_index,
    input  logic [WORD_OFF_BITS-1:0] wr_word,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     line_inval,
    input  logic                     line_fill,
    input  logic [TAG_W-1:0]         fill_tag
);

    localparam int LINES = num_lines(INDEX_BITS);

    logic [DATA_W-1:0] data_mem [LINES*LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_vec;

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            logic valid_d;
            logic valid_q;

            always_comb begin
                valid_d = valid_q;
                if (wr_index == INDEX_BITS'(gi)) begin
                    if (line_inval) valid_d = 1'b0;
                    if (line_fill)  valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) valid_q <= 1'b0;
                else     valid_q <= valid_d;
            end

            assign valid_vec[gi] = valid_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en)     data_mem[{wr_index, wr_word}] <= wr_data;
        if (line_fill) tag_mem[wr_index]             <= fill_tag;
    end

    assign rd_valid = valid_vec[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating stat_hits / stat_misses outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_rdaddress,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_wraddress,
    output logic [DATA_W-1:0] mem_write_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    localparam int TAG_W   = tag_w(ADDR_W, INDEX_BITS);
    localparam int WADDR_W = ADDR_W - BYTE_OFF_BITS;

    state_e                    state_q, state_d;
    logic [WORD_OFF_BITS-1:0]  cnt_q, cnt_d;
    logic [WADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;

    logic [WADDR_W-1:0]        look_waddr;
    logic [INDEX_BITS-1:0]     look_index;
    logic [WORD_OFF_BITS-1:0]  look_word;
    logic [TAG_W-1:0]          look_tag;
    logic                      rd_valid;
    logic [TAG_W-1:0]          rd_tag;
    logic [DATA_W-1:0]         rd_data;
    logic                      hit;

    logic                      ls_wr_en;
    logic [WORD_OFF_BITS-1:0]  ls_wr_word;
    logic [DATA_W-1:0]         ls_wr_data;
    logic                      ls_inval;
    logic                      ls_fill;
    logic                      hit_evt;
    logic                      miss_evt;

    logic                      unused_byte_bits;
    assign unused_byte_bits = ^cpu_addr[BYTE_OFF_BITS-1:0];

    // In IDLE the lookup follows the live request; elsewhere the latched one.
    assign look_waddr = (state_q == IDLE) ? cpu_addr[ADDR_W-1:BYTE_OFF_BITS] : addr_q;
    assign look_word  = look_waddr[WORD_OFF_BITS-1:0];
    assign look_index = look_waddr[WORD_OFF_BITS +: INDEX_BITS];
    assign look_tag   = look_waddr[WADDR_W-1 -: TAG_W];
    assign hit        = rd_valid && (rd_tag == look_tag);

    dcache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (look_index),
        .rd_word    (look_word),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_en      (ls_wr_en),
        .wr_index   (look_index),
        .wr_word    (ls_wr_word),
        .wr_data    (ls_wr_data),
        .line_inval (ls_inval),
        .line_fill  (ls_fill),
        .fill_tag   (look_tag)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        cpu_stall      = 1'b0;
        cpu_rdata      = '0;
        mem_rden       = 1'b0;
        mem_rdaddress  = '0;
        mem_wren       = 1'b0;
        mem_wraddress  = '0;
        mem_write_data = '0;
        ls_wr_en       = 1'b0;
        ls_wr_word     = look_word;
        ls_wr_data     = '0;
        ls_inval       = 1'b0;
        ls_fill        = 1'b0;
        hit_evt        = 1'b0;
        miss_evt       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        cpu_stall = 1'b1;
                        addr_d    = cpu_addr[ADDR_W-1:BYTE_OFF_BITS];
                        wdata_d   = cpu_wdata;
                        state_d   = WRITE;
                    end else if (hit) begin
                        cpu_rdata = rd_data;
                        hit_evt   = 1'b1;
                    end else begin
                        cpu_stall = 1'b1;
                        addr_d    = cpu_addr[ADDR_W-1:BYTE_OFF_BITS];
                        cnt_d     = '0;
                        miss_evt  = 1'b1;
                        state_d   = REFILL;
                    end
                end
            end
            REFILL: begin
                cpu_stall     = 1'b1;
                mem_rden      = 1'b1;
                mem_rdaddress = {addr_q[WADDR_W-1:WORD_OFF_BITS], cnt_q, {BYTE_OFF_BITS{1'b0}}};
                ls_wr_en      = 1'b1;
                ls_wr_word    = cnt_q;
                ls_wr_data    = mem_read_data;
                // Line stays invalid until its last word lands.
                ls_inval      = (cnt_q != WORD_OFF_BITS'(LINE_WORDS - 1));
                ls_fill       = (cnt_q == WORD_OFF_BITS'(LINE_WORDS - 1));
                cnt_d         = cnt_q + 1'b1;
                if (ls_fill) state_d = IDLE;
            end
            WRITE: begin
                mem_wren       = 1'b1;
                mem_wraddress  = {addr_q, {BYTE_OFF_BITS{1'b0}}};
                mem_write_data = wdata_q;
                ls_wr_en       = hit;
                ls_wr_data     = wdata_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            cpu_stall      = 1'b0;
            cpu_rdata      = '0;
            mem_rden       = 1'b0;
            mem_rdaddress  = '0;
            mem_wren       = 1'b0;
            mem_wraddress  = '0;
            mem_write_data = '0;
            ls_wr_en       = 1'b0;
            ls_inval       = 1'b0;
            ls_fill        = 1'b0;
            hit_evt        = 1'b0;
            miss_evt       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;

    always_comb begin
        hits_d   = (hit_evt  && hits_q   != 32'hFFFF_FFFF) ? hits_q   + 32'd1 : hits_q;
        misses_d = (miss_evt && misses_q != 32'hFFFF_FFFF) ? misses_q + 32'd1 : misses_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    logic unused_stat_evts;
    assign unused_stat_evts = hit_evt ^ miss_evt;
`endif

endmodule
